// File: rtl/sprite_fetch_scheduler.sv
// Sprite fetch scheduler: shares one single-read-port sprite memory between
// the background, brick and Mario sprite layers. Each accepted pixel slot runs
// a fixed 5-cycle sequence (BG read, brick read, sprite read, resolve) and
// emits one composited palette index with the winning layer.
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   pixel_tick             one-cycle strobe starting a pixel slot
//   blank                  1 = active video, 0 = blanked pixel
//   bg_addr                background local address
//   brick_addr, brick_hit  brick local address and in-region flag
//   spr_addr, spr_hit      sprite local address and in-box flag
//   mem_rd, mem_addr       shared memory read strobe / address
//   mem_data               read data, valid the cycle after mem_rd
//   pix_valid              one-cycle pulse, composited pixel ready
//   pix_index, pix_layer   composited index; layer 0=BG 1=BRICK 2=SPR 3=BLANK
//   busy                   pixel slot in progress
//   overrun                sticky: a pixel_tick arrived while busy
module sprite_fetch_scheduler #(
  parameter int                ADDR_W      = 19,
  parameter logic [ADDR_W-1:0] BG_BASE     = '0,
  parameter logic [ADDR_W-1:0] BRICK_BASE  = 19'h40000,
  parameter logic [ADDR_W-1:0] SPR_BASE    = 19'h60000,
  parameter logic [3:0]        TRANSPARENT = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_tick,
  input  logic              blank,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic [ADDR_W-1:0] brick_addr,
  input  logic              brick_hit,
  input  logic [ADDR_W-1:0] spr_addr,
  input  logic              spr_hit,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_data,
  output logic              pix_valid,
  output logic [3:0]        pix_index,
  output logic [1:0]        pix_layer,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, RD_BG, RD_BRICK, RD_SPR, RESOLVE} state_t;

  state_t            state_q, state_d;
  logic              blank_q, brick_hit_q, spr_hit_q;
  logic [ADDR_W-1:0] brick_addr_q, spr_addr_q;
  logic [3:0]        bg_data_q, bg_data_d, brick_data_q, brick_data_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic [3:0]        pix_index_q, pix_index_d;
  logic [1:0]        pix_layer_q, pix_layer_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              accept;

  // Layer priority: blanked > opaque sprite > opaque brick > background.
  // Returns {layer, index}. Background wins even when it is TRANSPARENT.
  function automatic logic [5:0] resolve_pix(
    input logic       blk,
    input logic       s_hit,
    input logic [3:0] s_dat,
    input logic       b_hit,
    input logic [3:0] b_dat,
    input logic [3:0] g_dat
  );
    if (!blk)                            return {2'd3, 4'h0};
    else if (s_hit && s_dat != TRANSPARENT) return {2'd2, s_dat};
    else if (b_hit && b_dat != TRANSPARENT) return {2'd1, b_dat};
    else                                 return {2'd0, g_dat};
  endfunction

  assign accept = (state_q == IDLE) && pixel_tick;

  // State register and all registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_index_q <= 4'h0;
      pix_layer_q <= 2'd3;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      pix_valid_q <= pix_valid_d;
      pix_index_q <= pix_index_d;
      pix_layer_q <= pix_layer_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Slot context and captured layer data; no reset needed since every
  // value is written before it is used in a slot.
  always_ff @(posedge Clk) begin
    if (accept) begin
      blank_q      <= blank;
      brick_hit_q  <= brick_hit;
      spr_hit_q    <= spr_hit;
      brick_addr_q <= brick_addr;
      spr_addr_q   <= spr_addr;
    end
    bg_data_q    <= bg_data_d;
    brick_data_q <= brick_data_d;
  end

  // Next-state: fixed slot sequence, every slot elapses even when not hit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (pixel_tick) state_d = RD_BG;
      RD_BG:    state_d = RD_BRICK;
      RD_BRICK: state_d = RD_SPR;
      RD_SPR:   state_d = RESOLVE;
      RESOLVE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output/next-value logic. Reads are issued one cycle ahead of the slot
  // they belong to so the strobe and address come straight from registers.
  always_comb begin
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    pix_valid_d  = 1'b0;
    pix_index_d  = pix_index_q;
    pix_layer_d  = pix_layer_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q | (pixel_tick & busy_q);
    bg_data_d    = bg_data_q;
    brick_data_d = brick_data_q;
    unique case (state_q)
      IDLE: begin
        if (pixel_tick) begin
          mem_rd_d   = blank;
          mem_addr_d = BG_BASE + bg_addr;
          busy_d     = 1'b1;
        end
      end
      RD_BG: begin
        mem_rd_d   = blank_q & brick_hit_q;
        mem_addr_d = BRICK_BASE + brick_addr_q;
      end
      RD_BRICK: begin
        mem_rd_d   = blank_q & spr_hit_q;
        mem_addr_d = SPR_BASE + spr_addr_q;
        bg_data_d  = mem_data;
      end
      RD_SPR: begin
        brick_data_d = mem_data;
      end
      RESOLVE: begin
        pix_valid_d = 1'b1;
        busy_d      = 1'b0;
        {pix_layer_d, pix_index_d} = resolve_pix(blank_q, spr_hit_q, mem_data,
                                                 brick_hit_q, brick_data_q,
                                                 bg_data_q);
      end
      default: ;
    endcase
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_index = pix_index_q;
  assign pix_layer = pix_layer_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Testbench for sprite_fetch_scheduler: table of pixel vectors plus
// hand-written overrun and mid-slot reset sequences; composited pixels are
// checked against a scoreboard queue filled when each tick is driven.
module tb_sprite_fetch_scheduler;

  localparam int          ADDR_W     = 19;
  localparam logic [18:0] BRICK_BASE = 19'h40000;
  localparam logic [18:0] SPR_BASE   = 19'h60000;

  logic              Clk = 1'b0;
  logic              Reset, pixel_tick, blank, brick_hit, spr_hit;
  logic [ADDR_W-1:0] bg_addr, brick_addr, spr_addr, mem_addr, mem_addr_r;
  logic              mem_rd, pix_valid, busy, overrun;
  logic [3:0]        mem_data, pix_index;
  logic [1:0]        pix_layer;
  logic [3:0]        bg_val, brick_val, spr_val;

  sprite_fetch_scheduler #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .pixel_tick(pixel_tick), .blank(blank),
    .bg_addr(bg_addr), .brick_addr(brick_addr), .brick_hit(brick_hit),
    .spr_addr(spr_addr), .spr_hit(spr_hit), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_valid(pix_valid),
    .pix_index(pix_index), .pix_layer(pix_layer), .busy(busy),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Memory model: one-cycle read latency, region decided by address. Data is
  // returned even without mem_rd so that ignored slots are really exercised.
  always @(posedge Clk) mem_addr_r <= mem_addr;
  assign mem_data = (mem_addr_r < BRICK_BASE) ? bg_val :
                    (mem_addr_r < SPR_BASE)   ? brick_val : spr_val;

  typedef struct {
    logic [3:0] idx;
    logic [1:0] layer;
    int         cyc;
  } exp_t;

  typedef struct {
    logic              blank;
    logic [ADDR_W-1:0] bg_a, bk_a, sp_a;
    logic              bh, sh;
    logic [3:0]        bgv, bkv, spv;
    logic [3:0]        eidx;
    logic [1:0]        elay;
  } vec_t;

  exp_t sb[$];
  exp_t got_e;
  vec_t vt[9];
  int   cyc  = 0;
  int   nchk = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor: every pix_valid must match the oldest expectation,
  // including the cycle it was due in.
  always begin
    @(posedge Clk);
    cyc++;
    #1;
    if (pix_valid === 1'b1) begin
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_pix_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        got_e = sb.pop_front();
        check("pix_cycle", cyc, got_e.cyc);
        check("pix_index", {28'd0, pix_index}, {28'd0, got_e.idx});
        check("pix_layer", {30'd0, pix_layer}, {30'd0, got_e.layer});
      end
    end
  end

  // Drive one pixel tick and check the read slots; leaves the bench at k+5.
  task automatic run_vec(input vec_t v);
    logic [ADDR_W-1:0] ea;
    exp_t e;
    bg_val = v.bgv; brick_val = v.bkv; spr_val = v.spv;
    blank = v.blank; bg_addr = v.bg_a; brick_addr = v.bk_a; spr_addr = v.sp_a;
    brick_hit = v.bh; spr_hit = v.sh; pixel_tick = 1'b1;
    e.idx = v.eidx; e.layer = v.elay; e.cyc = cyc + 5;
    sb.push_back(e);
    step();  // k+1
    pixel_tick = 1'b0;
    blank = ~v.blank; brick_hit = ~v.bh; spr_hit = ~v.sh;
    bg_addr = 19'h01234; brick_addr = 19'h00777; spr_addr = 19'h00555;
    check("busy_k1", {31'd0, busy}, 32'd1);
    check("rd_bg", {31'd0, mem_rd}, {31'd0, v.blank});
    check("addr_bg", {13'd0, mem_addr}, {13'd0, v.bg_a});
    step();  // k+2
    ea = BRICK_BASE + v.bk_a;
    check("rd_brick", {31'd0, mem_rd}, {31'd0, v.blank & v.bh});
    check("addr_brick", {13'd0, mem_addr}, {13'd0, ea});
    step();  // k+3
    ea = SPR_BASE + v.sp_a;
    check("rd_spr", {31'd0, mem_rd}, {31'd0, v.blank & v.sh});
    check("addr_spr", {13'd0, mem_addr}, {13'd0, ea});
    step();  // k+4
    check("rd_idle", {31'd0, mem_rd}, 32'd0);
    check("addr_hold", {13'd0, mem_addr}, {13'd0, ea});
    check("busy_k4", {31'd0, busy}, 32'd1);
    step();  // k+5
    check("busy_k5", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    //        blank bg_a     bk_a     sp_a       bh    sh    bgv   bkv   spv   eidx  elay
    vt[0] = '{1'b1, 19'd5,  19'd0,   19'd0,     1'b0, 1'b0, 4'h7, 4'h9, 4'h3, 4'h7, 2'd0};
    vt[1] = '{1'b1, 19'd10, 19'd3,   19'd2,     1'b1, 1'b1, 4'h1, 4'h9, 4'h0, 4'h9, 2'd1};
    vt[2] = '{1'b1, 19'd10, 19'd3,   19'd2,     1'b1, 1'b1, 4'h1, 4'h9, 4'hC, 4'hC, 2'd2};
    vt[3] = '{1'b1, 19'd10, 19'd3,   19'd2,     1'b0, 1'b1, 4'h1, 4'h9, 4'hC, 4'hC, 2'd2};
    vt[4] = '{1'b1, 19'd11, 19'd3,   19'd2,     1'b0, 1'b1, 4'h1, 4'h9, 4'h0, 4'h1, 2'd0};
    vt[5] = '{1'b0, 19'd10, 19'd3,   19'd2,     1'b1, 1'b1, 4'h1, 4'h9, 4'hC, 4'h0, 2'd3};
    vt[6] = '{1'b1, 19'd20, 19'd8,   19'd9,     1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
    vt[7] = '{1'b1, 19'd21, 19'd4,   19'd6,     1'b1, 1'b0, 4'h2, 4'h5, 4'hC, 4'h5, 2'd1};
    // Sprite address wraps to 19'h5FFFF, which the memory decodes as brick data.
    vt[8] = '{1'b1, 19'd0,  19'd0,   19'h7FFFF, 1'b0, 1'b1, 4'h2, 4'h6, 4'h3, 4'h6, 2'd2};

    Reset = 1'b1; pixel_tick = 1'b0; blank = 1'b0; brick_hit = 1'b0;
    spr_hit = 1'b0; bg_addr = '0; brick_addr = '0; spr_addr = '0;
    bg_val = 4'h0; brick_val = 4'h0; spr_val = 4'h0;
    repeat (3) step();
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_index", {28'd0, pix_index}, 32'd0);
    check("rst_pix_layer", {30'd0, pix_layer}, 32'd3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    Reset = 1'b0;

    // Back-to-back vectors, each new tick at k+5 of the previous one
    for (int i = 0; i < 9; i++) run_vec(vt[i]);
    check("no_overrun_b2b", {31'd0, overrun}, 32'd0);

    // Overrun: tick at c0, dropped tick at c0+3, accepted tick at c0+5
    bg_val = 4'h7; blank = 1'b1; bg_addr = 19'd5; brick_hit = 1'b0; spr_hit = 1'b0;
    pixel_tick = 1'b1;
    sb.push_back('{4'h7, 2'd0, cyc + 5});
    step(); pixel_tick = 1'b0;
    step();
    step(); pixel_tick = 1'b1; bg_val = 4'h3;
    step(); pixel_tick = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("busy_after_drop", {31'd0, busy}, 32'd1);
    step();
    bg_val = 4'h7;
    pixel_tick = 1'b1;
    sb.push_back('{4'h7, 2'd0, cyc + 5});
    step(); pixel_tick = 1'b0;
    check("busy_accept_k5", {31'd0, busy}, 32'd1);
    repeat (5) step();
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset in k+2 aborts the slot; tick coincident with reset is ignored
    bg_val = 4'hA; blank = 1'b1; bg_addr = 19'd7; pixel_tick = 1'b1;
    step(); pixel_tick = 1'b0;               // k+1
    step(); Reset = 1'b1; pixel_tick = 1'b1; // k+2
    step(); Reset = 1'b0; pixel_tick = 1'b0; // k+3
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("abort_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    check("abort_pix_layer", {30'd0, pix_layer}, 32'd3);
    check("abort_pix_index", {28'd0, pix_index}, 32'd0);
    check("abort_pix_valid", {31'd0, pix_valid}, 32'd0);
    step();                                  // k+4
    check("rst_tick_ignored", {31'd0, busy}, 32'd0);
    step();                                  // k+5
    run_vec(vt[1]);

    repeat (4) step();
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
